upscale3x_scheduler: RTL

UPSCALE3X_SCHEDULER -- requirements
Module: upscale3x_scheduler

---
 rtl/upscale_pkg.sv | 12 +
 rtl/upscale3x_scheduler_phase3_ctr.sv | 37 +++
 rtl/upscale3x_scheduler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/upscale_pkg.sv
// rtl/upscale_pkg.sv - shared scheduler state encoding and replication factor
package upscale_pkg;

  localparam int SCALE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/upscale3x_scheduler_phase3_ctr.sv
// rtl/upscale3x_scheduler_phase3_ctr.sv - 0..SCALE-1 replica counter, wrap flags terminal count
module phase3_ctr
  import upscale_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [1:0] q,
  output logic       wrap
);

  localparam logic [1:0] LAST_PHASE = 2'(SCALE - 1);

  logic [1:0] q_q, q_d;

  assign wrap = (q_q == LAST_PHASE);
  assign q    = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 2'd0;
    end else if (en) begin
      q_d = wrap ? 2'd0 : q_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 2'd0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/upscale3x_scheduler.sv
// rtl/upscale3x_scheduler.sv - 3x nearest-neighbour read-address scheduler; UPSC_ABORT_EN adds abort input
module upscale3x_scheduler
  import upscale_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef UPSC_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] src_addr,
  output logic [1:0]        col_phase,
  output logic [1:0]        row_phase,
  output logic              eol
);

  localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_Y = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] x_q, x_d, y_q, y_d, base_q, base_d;
  logic xfer, col_wrap, row_wrap, last_x, row_end, frame_end, abort_w, clr;

`ifdef UPSC_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign xfer      = out_valid && out_ready;
  assign last_x    = (x_q == LAST_X);
  assign eol       = last_x && col_wrap;
  assign row_end   = xfer && eol;
  assign frame_end = row_end && row_wrap && (y_q == LAST_Y);
  // Address tracks line base plus column so no multiplier is needed
  assign src_addr  = base_q + x_q;

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        clr     = 1'b1;
      end
      RUN: if (abort_w) begin
        state_d = IDLE;
        clr     = 1'b1;
      end else if (frame_end) begin
        state_d = DONE;
        clr     = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    base_d = base_q;
    if (clr) begin
      x_d    = '0;
      y_d    = '0;
      base_d = '0;
    end else begin
      if (xfer && col_wrap) begin
        x_d = last_x ? '0 : x_q + 1'b1;
      end
      if (row_end && row_wrap) begin
        y_d    = y_q + 1'b1;
        base_d = base_q + LINE_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
    end
  end

  phase3_ctr u_col_ctr (
    .clk  (clk),
    .rst  (rst),
    .en   (xfer),
    .clr  (clr),
    .q    (col_phase),
    .wrap (col_wrap)
  );

  phase3_ctr u_row_ctr (
    .clk  (clk),
    .rst  (rst),
    .en   (row_end),
    .clr  (clr),
    .q    (row_phase),
    .wrap (row_wrap)
  );

endmodule
